// File: rtl/i2s_pkg.sv
// Shared definitions for the AHB-Lite I2S transmitter: register offsets, STATUS/CTRL bit
// positions, default read value and slot geometry.
package i2s_pkg;

   localparam logic [23:0] REG_CTRL   = 24'h00_0000;
   localparam logic [23:0] REG_STATUS = 24'h00_0004;
   localparam logic [23:0] REG_DATA   = 24'h00_0008;
   localparam logic [23:0] REG_LEVEL  = 24'h00_000C;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_FLUSH = 1;
   localparam int CTRL_IE    = 2;

   localparam int STAT_FULL     = 0;
   localparam int STAT_EMPTY    = 1;
   localparam int STAT_UNDERRUN = 2;
   localparam int STAT_OVERFLOW = 3;

   localparam logic [31:0] RD_DEFAULT = 32'hBADD_BEEF;

   localparam int SLOT_BITS = 32;
   localparam int FRAME_POS = 2 * SLOT_BITS;

   // Address-phase snapshot carried into the data phase
   typedef struct packed {
      logic [23:0] addr;
      logic        trans;
      logic        sel;
      logic        write;
   } ahb_aph_t;

endpackage

// File: rtl/i2s_tx_core.sv
// I2S serialiser: SCK divider, 64-position frame counter, slot shifter and SCK/WS/SD generation.
// Pops one FIFO word at the start of each slot and flags an underrun when none is available.
module i2s_tx_core
   import i2s_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 fifo_empty_i,
   input  logic [SLOT_BITS-1:0] fifo_data_i,
   output logic                 fifo_pop_o,
   output logic                 underrun_o,
   output logic                 sck_o,
   output logic                 ws_o,
   output logic                 sd_o
);

   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam int POS_W = $clog2(FRAME_POS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
   localparam logic [POS_W-1:0] WS_FIRST = POS_W'(SLOT_BITS - 1);
   localparam logic [POS_W-1:0] WS_LAST  = POS_W'(FRAME_POS - 2);

   logic [DIV_W-1:0]     div_q, div_d;
   logic [POS_W-1:0]     pos_q, pos_d;
   logic [SLOT_BITS-1:0] shift_q, shift_d;
   logic                 load;
   logic                 pos_end;
   logic [SLOT_BITS-1:0] cur_word;

   // The load cycle presents the FIFO head directly so SD carries the MSB from position start
   assign load     = en_i && (div_q == '0) && (pos_q[POS_W-2:0] == '0);
   assign pos_end  = (div_q == DIV_LAST);
   assign cur_word = load ? (fifo_empty_i ? '0 : fifo_data_i) : shift_q;

   always_comb begin
      div_d   = div_q;
      pos_d   = pos_q;
      shift_d = shift_q;
      if (!en_i) begin
         div_d   = '0;
         pos_d   = '0;
         shift_d = '0;
      end else if (pos_end) begin
         div_d   = '0;
         pos_d   = pos_q + 1'b1;
         shift_d = cur_word << 1;
      end else begin
         div_d   = div_q + 1'b1;
         shift_d = cur_word;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         div_q   <= '0;
         pos_q   <= '0;
         shift_q <= '0;
      end else begin
         div_q   <= div_d;
         pos_q   <= pos_d;
         shift_q <= shift_d;
      end
   end

   assign fifo_pop_o = load && !fifo_empty_i;
   assign underrun_o = load && fifo_empty_i;
   assign sck_o      = en_i && (div_q >= DIV_HALF);
   assign ws_o       = en_i && (pos_q >= WS_FIRST) && (pos_q <= WS_LAST);
   assign sd_o       = en_i && cur_word[SLOT_BITS-1];

endmodule

// File: rtl/ahbl_i2s_tx.sv
// AHB-Lite I2S transmitter: register decode, TX FIFO and status flags around i2s_tx_core.
// Optional IRQ output is enabled by defining I2S_TX_IRQ_EN.
module ahbl_i2s_tx
   import i2s_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_AW    = 3
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HSEL,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        SCK,
   output logic        WS,
   output logic        SD
`ifdef I2S_TX_IRQ_EN
 , output logic        IRQ
`endif
);

   localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(FIFO_DEPTH);

   ahb_aph_t             aph_q, aph_d;
   logic                 we, re;
   logic                 en_q, en_d, ie_q, ie_d, flush_q, flush_d;
   logic                 und_q, und_d, ovf_q, ovf_d;
   logic [SLOT_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]     cnt_q, cnt_d;
   logic                 full, empty, push_req, push, pop, core_und;
   logic                 unused_sig;

   assign unused_sig = ^{HSIZE, HADDR[31:24], HTRANS[0]};
   assign HREADYOUT  = 1'b1;

   always_comb begin
      aph_d = aph_q;
      if (HREADY) begin
         aph_d.addr  = HADDR[23:0];
         aph_d.trans = HTRANS[1];
         aph_d.sel   = HSEL;
         aph_d.write = HWRITE;
      end
   end

   assign we = aph_q.trans && aph_q.sel && aph_q.write;
   assign re = aph_q.trans && aph_q.sel && !aph_q.write;

   assign full     = (cnt_q == DEPTH);
   assign empty    = (cnt_q == '0);
   assign push_req = we && (aph_q.addr == REG_DATA);
   // A full FIFO still accepts a push when the serialiser pops in the same cycle
   assign push     = push_req && (!full || pop) && !flush_q;

   always_comb begin
      en_d    = en_q;
      ie_d    = ie_q;
      flush_d = 1'b0;
      und_d   = und_q;
      ovf_d   = ovf_q;
      if (we && (aph_q.addr == REG_CTRL)) begin
         en_d    = HWDATA[CTRL_EN];
         flush_d = HWDATA[CTRL_FLUSH];
         ie_d    = HWDATA[CTRL_IE];
      end
      if (we && (aph_q.addr == REG_STATUS)) begin
         if (HWDATA[STAT_UNDERRUN]) und_d = 1'b0;
         if (HWDATA[STAT_OVERFLOW]) ovf_d = 1'b0;
      end
      if (core_und) und_d = 1'b1;
      if (push_req && full && !pop && !flush_q) ovf_d = 1'b1;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_q) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      cnt_d = cnt_q + 1'b1;
         else if (pop && !push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         aph_q    <= '0;
         en_q     <= 1'b0;
         ie_q     <= 1'b0;
         flush_q  <= 1'b0;
         und_q    <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         aph_q    <= aph_d;
         en_q     <= en_d;
         ie_q     <= ie_d;
         flush_q  <= flush_d;
         und_q    <= und_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge HCLK) begin
      if (push) mem_q[wr_ptr_q] <= HWDATA;
   end

   always_comb begin
      HRDATA = '0;
      if (re) begin
         case (aph_q.addr)
            REG_CTRL: begin
               HRDATA[CTRL_EN] = en_q;
               HRDATA[CTRL_IE] = ie_q;
            end
            REG_STATUS: begin
               HRDATA[STAT_FULL]     = full;
               HRDATA[STAT_EMPTY]    = empty;
               HRDATA[STAT_UNDERRUN] = und_q;
               HRDATA[STAT_OVERFLOW] = ovf_q;
            end
            REG_DATA:  HRDATA = '0;
            REG_LEVEL: HRDATA[FIFO_AW:0] = cnt_q;
            default:   HRDATA = RD_DEFAULT;
         endcase
      end
   end

   i2s_tx_core #(
      .CLK_DIV (CLK_DIV)
   ) u_core (
      .clk_i        (HCLK),
      .rst_ni       (HRESETn),
      .en_i         (en_q),
      .fifo_empty_i (empty),
      .fifo_data_i  (mem_q[rd_ptr_q]),
      .fifo_pop_o   (pop),
      .underrun_o   (core_und),
      .sck_o        (SCK),
      .ws_o         (WS),
      .sd_o         (SD)
   );

`ifdef I2S_TX_IRQ_EN
   localparam logic [FIFO_AW:0] HALF = (FIFO_AW + 1)'(FIFO_DEPTH / 2);

   logic irq_q, irq_d;

   assign irq_d = ie_q && (und_q || (cnt_q < HALF));

   always_ff @(posedge HCLK) begin
      if (!HRESETn) irq_q <= 1'b0;
      else          irq_q <= irq_d;
   end

   assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_ahbl_i2s_tx.sv
// Self-checking bench for ahbl_i2s_tx: random FIFO traffic and frame lengths against a queue-based
// model of the FIFO, sticky flags and the I2S slot/WS pattern recovered from SCK rising edges.
module tb_ahbl_i2s_tx;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 8;
   localparam int AW      = 3;
   localparam int PER     = 2 * CLK_DIV;

   localparam logic [31:0] A_CTRL   = 32'h0;
   localparam logic [31:0] A_STATUS = 32'h4;
   localparam logic [31:0] A_DATA   = 32'h8;
   localparam logic [31:0] A_LEVEL  = 32'hC;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = '0;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'b010;
   logic [31:0] HWDATA = '0;
   logic        HSEL = 1'b0;
   logic        HREADY = 1'b1;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        SCK, WS, SD;
`ifdef I2S_TX_IRQ_EN
   logic        IRQ;
`endif

   always #5 HCLK = ~HCLK;

   ahbl_i2s_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (DEPTH),
      .FIFO_AW    (AW)
   ) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HSEL      (HSEL),
      .HREADY    (HREADY),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .SCK       (SCK),
      .WS        (WS),
      .SD        (SD)
`ifdef I2S_TX_IRQ_EN
    , .IRQ       (IRQ)
`endif
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: FIFO contents, sticky flags, control bits
   logic [31:0] mq[$];
   bit          m_und = 1'b0;
   bit          m_ovf = 1'b0;
   bit          m_ie  = 1'b0;

   // Line monitor: {WS,SD} and cycle stamp at every observed SCK rise
   logic [1:0] cap[$];
   int         rise_t[$];
   int         cyc = 0;
   logic       sck_prev = 1'b0;

   always @(negedge HCLK) begin
      if (SCK && !sck_prev) begin
         cap.push_back({WS, SD});
         rise_t.push_back(cyc);
      end
      sck_prev <= SCK;
      cyc      <= cyc + 1;
   end

   // Bus tasks are entered and left 1 time unit after a rising edge
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      @(posedge HCLK); #1;
   endtask

   task automatic bus_wr2(input logic [31:0] a1, input logic [31:0] d1,
                          input logic [31:0] a2, input logic [31:0] d2);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a1;
      @(posedge HCLK); #1;
      HWDATA = d1; HADDR = a2;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d2;
      @(posedge HCLK); #1;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      d = HRDATA;
   endtask

   task automatic push(input logic [31:0] w);
      bus_wr(A_DATA, w);
      if (mq.size() < DEPTH) mq.push_back(w);
      else                   m_ovf = 1'b1;
   endtask

   task automatic clear_sticky();
      bus_wr(A_STATUS, 32'hC);
      m_und = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      logic [31:0] d;
      bus_rd(A_LEVEL, d);
      check_eq($sformatf("%s_level", tag), d, 32'(mq.size()));
      bus_rd(A_STATUS, d);
      check_eq($sformatf("%s_status", tag), d,
               {28'd0, m_ovf, m_und, mq.size() == 0, mq.size() == DEPTH});
      bus_rd(A_CTRL, d);
      check_eq($sformatf("%s_ctrl", tag), d, {29'd0, m_ie, 2'b00});
   endtask

   // Enable, let n SCK rises go by, disable, then rebuild each slot from the captured bits
   task automatic run_and_check(input int n_req, input string tag);
      int base, waited, n, loads, ws_bad, per_bad, nb, p;
      logic [31:0] w, got, mask;
      base = cap.size();
      bus_wr(A_CTRL, {29'd0, m_ie, 2'b01});
      waited = 0;
      while (cap.size() < base + n_req && waited < n_req * PER + 100) begin
         @(posedge HCLK);
         waited++;
      end
      #1;
      n = cap.size() - base;
      if (n < n_req) check_eq($sformatf("%s_timeout", tag), 32'(n), 32'(n_req));
      bus_wr(A_CTRL, {29'd0, m_ie, 2'b00});
      check_eq($sformatf("%s_off_line", tag), {29'd0, SCK, WS, SD}, 32'd0);
      if (n > n_req) n = n_req;
      if (n == 0) return;
      ws_bad  = 0;
      per_bad = 0;
      for (int k = 0; k < n; k++) begin
         p = k % 64;
         if (cap[base + k][1] !== ((p >= 31) && (p <= 62))) ws_bad++;
         if (k > 0 && (rise_t[base + k] - rise_t[base + k - 1]) != PER) per_bad++;
      end
      check_eq($sformatf("%s_ws", tag), 32'(ws_bad), 32'd0);
      check_eq($sformatf("%s_sck_period", tag), 32'(per_bad), 32'd0);
      loads = (n - 1) / 32 + 1;
      for (int s = 0; s < loads; s++) begin
         if (mq.size() > 0) w = mq.pop_front();
         else begin
            w = 32'd0;
            m_und = 1'b1;
         end
         nb = (n - 32 * s < 32) ? (n - 32 * s) : 32;
         got = 32'd0;
         for (int b = 0; b < nb; b++) got[31 - b] = cap[base + 32 * s + b][0];
         mask = ~(32'hFFFF_FFFF >> nb);
         check_eq($sformatf("%s_slot%0d", tag, s), got, w & mask);
      end
   endtask

   initial begin
      logic [31:0] d;

      repeat (3) @(posedge HCLK);
      #1;
      check_eq("rst_line", {29'd0, SCK, WS, SD}, 32'd0);
`ifdef I2S_TX_IRQ_EN
      check_eq("rst_irq", {31'd0, IRQ}, 32'd0);
`endif
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      check_regs("rst");
      bus_rd(A_DATA, d);
      check_eq("rst_data_rd", d, 32'd0);
      bus_rd(32'h10, d);
      check_eq("rst_bad_off", d, 32'hBADD_BEEF);
      check_eq("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);

      // Two known words: left then right slot
      push(32'hA5A5_F00F);
      push(32'h1234_5678);
      run_and_check(64, "basic");
      check_regs("basic_post");

      // Empty FIFO: whole frame silent, underrun sticky until write-1-to-clear
      run_and_check(64, "undr");
      check_regs("undr_post");
      bus_wr(A_STATUS, 32'h4);
      m_und = 1'b0;
      check_regs("undr_clr");

      // Nine pushes into eight entries
      for (int i = 0; i < 9; i++) push($urandom);
      check_regs("ovf");
      run_and_check(256, "ovf_run");
      check_regs("ovf_post");
      clear_sticky();

      // Disable during p=10 of the left slot, then restart from the left slot
      for (int i = 0; i < 3; i++) push($urandom);
      run_and_check(11, "midoff");
      run_and_check(64, "reen");
      check_regs("reen_post");
      clear_sticky();

      for (int it = 0; it < 6; it++) begin
         int np;
         np = $urandom_range(0, 9);
         for (int i = 0; i < np; i++) push($urandom);
         check_regs($sformatf("rnd%0d_pre", it));
         run_and_check($urandom_range(1, 150), $sformatf("rnd%0d", it));
         check_regs($sformatf("rnd%0d_post", it));
         if ($urandom_range(0, 1) == 1) clear_sticky();
      end

      // FLUSH with a DATA push landing in the flush cycle
      clear_sticky();
      while (mq.size() < 5) push($urandom);
      check_regs("flush_pre");
      m_ie = 1'b1;
      bus_wr2(A_CTRL, 32'h6, A_DATA, $urandom);
      mq.delete();
      check_regs("flush_post");
`ifdef I2S_TX_IRQ_EN
      check_eq("flush_irq", {31'd0, IRQ}, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
